// File: rtl/traceback_if.sv
// Port bundle for the segment traceback engine: backpointer writes, trace
// control, and the segment result stream.
interface traceback_if #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5
);
  localparam int IW = $clog2(I);
  localparam int KW = $clog2(FORMANTS);

  logic                 wr_valid;
  logic [IW-1:0]        wr_i;
  logic [KW-1:0]        wr_k;
  logic [BIT_WIDTH-1:0] wr_b;
  logic                 start_trace;
  logic [IW-1:0]        end_i;
  logic [KW-1:0]        num_k;
  logic                 busy;
  logic                 seg_valid;
  logic [KW-1:0]        seg_k;
  logic [IW-1:0]        seg_start;
  logic [IW-1:0]        seg_end;
  logic                 trace_done;
  logic                 trace_err;

  modport master (
    output wr_valid, wr_i, wr_k, wr_b, start_trace, end_i, num_k,
    input  busy, seg_valid, seg_k, seg_start, seg_end, trace_done, trace_err
  );

  modport slave (
    input  wr_valid, wr_i, wr_k, wr_b, start_trace, end_i, num_k,
    output busy, seg_valid, seg_k, seg_start, seg_end, trace_done, trace_err
  );
endinterface

// File: rtl/traceback.sv
// Segment traceback: walks stored backpointers B(k,i) from (num_k,end_i) down
// to k=1, emitting one segment (k, j+1, i) every three cycles.
module traceback #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int FORMANTS  = 5
) (
  input logic        clk_in,
  input logic        rst_in,
  traceback_if.slave bus
);
  localparam int IW = $clog2(I);
  localparam int KW = $clog2(FORMANTS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [1:0]           state;
  logic [IW-1:0]        i_cur;
  logic [KW-1:0]        k_cur;
  logic                 busy;
  logic                 seg_valid;
  logic [KW-1:0]        seg_k;
  logic [IW-1:0]        seg_start;
  logic [IW-1:0]        seg_end;
  logic                 trace_done;
  logic                 trace_err;

  logic signed [IW:0]   mem [FORMANTS][I];
  logic [KW-1:0]        rd_row;
  logic [IW-1:0]        rd_col;
  logic signed [IW:0]   rd_data;
  logic signed [IW:0]   j_inc;

  logic                 wr_ok;
  logic                 start_bad;
  logic                 chk_err;
  logic                 last_seg;
  logic                 unused_wr_b;

  assign unused_wr_b = ^bus.wr_b[BIT_WIDTH-1:IW+1];

  always_comb begin
    wr_ok     = 1'b0;
    start_bad = 1'b0;
    chk_err   = 1'b0;
    last_seg  = 1'b0;
    j_inc     = rd_data + (IW+1)'(1);
    wr_ok     = bus.wr_valid && !busy && (bus.wr_k != '0)
                && (int'(bus.wr_k) <= FORMANTS) && (int'(bus.wr_i) < I);
    start_bad = (bus.num_k == '0) || (int'(bus.num_k) > FORMANTS)
                || (int'(bus.num_k) > int'(bus.end_i) + 1);
    // j is signed; the cursors are zero-extended before comparison
    chk_err   = (int'(rd_data) >= int'(i_cur))
                || (int'(rd_data) < int'(k_cur) - 2)
                || ((k_cur == KW'(1)) && (rd_data != '1));
    last_seg  = (k_cur == KW'(1)) || chk_err;
  end

  // Backpointer store is never reset; address and data are both registered,
  // so data for an address presented in REQ is usable in CHECK.
  always_ff @(posedge clk_in) begin
    if (wr_ok)
      mem[bus.wr_k - KW'(1)][bus.wr_i] <= bus.wr_b[IW:0];
    if (state == ST_REQ) begin
      rd_row <= k_cur - KW'(1);
      rd_col <= i_cur;
    end
    rd_data <= mem[rd_row][rd_col];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      i_cur      <= '0;
      k_cur      <= '0;
      busy       <= 1'b0;
      seg_valid  <= 1'b0;
      seg_k      <= '0;
      seg_start  <= '0;
      seg_end    <= '0;
      trace_done <= 1'b0;
      trace_err  <= 1'b0;
    end else begin
      seg_valid  <= 1'b0;
      trace_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // busy lingers through the trace_done cycle, so starts wait one more
          if (busy) begin
            busy <= 1'b0;
          end else if (bus.start_trace) begin
            i_cur <= bus.end_i;
            k_cur <= bus.num_k;
            if (start_bad) begin
              trace_err  <= 1'b1;
              trace_done <= 1'b1;
            end else begin
              trace_err <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ:  state <= ST_WAIT;
        ST_WAIT: state <= ST_CHECK;
        ST_CHECK: begin
          seg_valid <= 1'b1;
          seg_k     <= k_cur;
          seg_start <= j_inc[IW-1:0];
          seg_end   <= i_cur;
          if (chk_err)
            trace_err <= 1'b1;
          if (last_seg) begin
            trace_done <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            i_cur <= rd_data[IW-1:0];
            k_cur <= k_cur - KW'(1);
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.seg_valid  = seg_valid;
  assign bus.seg_k      = seg_k;
  assign bus.seg_start  = seg_start;
  assign bus.seg_end    = seg_end;
  assign bus.trace_done = trace_done;
  assign bus.trace_err  = trace_err;
endmodule

// File: tb/tb_traceback.sv
// Directed bench for traceback: hand-computed segment schedules, illegal
// starts, busy-time interference, mid-trace reset and error boundaries.
module tb_traceback;
  localparam int BW = 32;
  localparam int NI = 160;
  localparam int NF = 5;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] ek [4];
  logic [31:0] es [4];
  logic [31:0] ee [4];

  traceback_if #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF)) bus ();

  traceback #(.BIT_WIDTH(BW), .I(NI), .FORMANTS(NF)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int k, input int i, input logic [31:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_k     = 3'(k);
    bus.wr_i     = 8'(i);
    bus.wr_b     = b;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},       32'(bus.busy),       32'd0);
    check({tag, ".seg_valid"},  32'(bus.seg_valid),  32'd0);
    check({tag, ".trace_done"}, 32'(bus.trace_done), 32'd0);
    check({tag, ".trace_err"},  32'(bus.trace_err),  32'd0);
    check({tag, ".seg_k"},      32'(bus.seg_k),      32'd0);
    check({tag, ".seg_start"},  32'(bus.seg_start),  32'd0);
    check({tag, ".seg_end"},    32'(bus.seg_end),    32'd0);
  endtask

  // Start at cycle t, then check every cycle t+1 .. last+1. Ends in the cycle
  // where busy has just fallen, so a following start lands right there.
  task automatic run_trace(input int ei, input int nk, input int nseg,
                           input bit legal, input bit err_exp, input bit inject);
    int last;
    int idx;
    bit sv;
    idx = 0;
    bus.start_trace = 1'b1;
    bus.end_i       = 8'(ei);
    bus.num_k       = 3'(nk);
    tick();
    bus.start_trace = 1'b0;
    last = legal ? 3 * nseg + 1 : 1;
    for (int c = 1; c <= last + 1; c++) begin
      sv = legal && (c >= 4) && (((c - 4) % 3) == 0) && (idx < nseg);
      check("seg_valid", 32'(bus.seg_valid), 32'(sv));
      if (sv) begin
        check("seg_k",     32'(bus.seg_k),     ek[idx]);
        check("seg_start", 32'(bus.seg_start), es[idx]);
        check("seg_end",   32'(bus.seg_end),   ee[idx]);
        idx++;
      end
      check("trace_done", 32'(bus.trace_done), 32'(c == last));
      if (c >= last)
        check("trace_err", 32'(bus.trace_err), 32'(err_exp));
      check("busy", 32'(bus.busy), 32'(legal && (c <= last)));
      if (inject && c == 2) begin
        bus.wr_valid    = 1'b1;
        bus.wr_k        = 3'd3;
        bus.wr_i        = 8'd9;
        bus.wr_b        = 32'd1;
        bus.start_trace = 1'b1;
        bus.end_i       = 8'd5;
        bus.num_k       = 3'd1;
      end
      if (c <= last) begin
        tick();
        bus.wr_valid    = 1'b0;
        bus.start_trace = 1'b0;
      end
    end
  endtask

  task automatic set_basic();
    ek[0] = 3; es[0] = 7; ee[0] = 9;
    ek[1] = 2; es[1] = 3; ee[1] = 6;
    ek[2] = 1; es[2] = 0; ee[2] = 2;
  endtask

  task automatic load_basic();
    wr(3, 9, 32'd6);
    wr(2, 6, 32'd2);
    wr(1, 2, 32'hFFFF_FFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid    = 1'b0;
    bus.wr_i        = '0;
    bus.wr_k        = '0;
    bus.wr_b        = '0;
    bus.start_trace = 1'b0;
    bus.end_i       = '0;
    bus.num_k       = '0;
    #1 rst_in = 1'b1;
    #11;
    check_all_zero("reset");
    tick();
    rst_in = 1'b0;

    load_basic();
    set_basic();
    run_trace(9, 3, 3, 1'b1, 1'b0, 1'b1);
    run_trace(9, 3, 3, 1'b1, 1'b0, 1'b0);

    wr(1, 2, 32'd0);
    es[2] = 1;
    run_trace(9, 3, 3, 1'b1, 1'b1, 1'b0);
    wr(1, 2, 32'hFFFF_FFFF);
    es[2] = 0;

    run_trace(9, 0, 0, 1'b0, 1'b1, 1'b0);
    run_trace(2, 4, 0, 1'b0, 1'b1, 1'b0);
    run_trace(9, 6, 0, 1'b0, 1'b1, 1'b0);

    // Abort a running trace at t+5 with an asynchronous reset
    bus.start_trace = 1'b1;
    bus.end_i       = 8'd9;
    bus.num_k       = 3'd3;
    tick();
    bus.start_trace = 1'b0;
    repeat (4) tick();
    rst_in = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst_in = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("post_reset.seg_valid",  32'(bus.seg_valid),  32'd0);
      check("post_reset.trace_done", 32'(bus.trace_done), 32'd0);
      check("post_reset.busy",       32'(bus.busy),       32'd0);
      tick();
    end
    load_basic();
    run_trace(9, 3, 3, 1'b1, 1'b0, 1'b0);

    wr(1, 0, 32'hFFFF_FFFF);
    ek[0] = 1; es[0] = 0; ee[0] = 0;
    run_trace(0, 1, 1, 1'b1, 1'b0, 1'b0);

    // j equal to i is the first illegal backpointer value
    wr(3, 9, 32'd9);
    ek[0] = 3; es[0] = 10; ee[0] = 9;
    run_trace(9, 3, 1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
